uart_cmd_seq: RTL

UART_CMD_SEQ -- requirements
Module: uart_cmd_seq

---
 rtl/uart_cmd_seq.sv | 121 ++++++++++++
 1 files changed

// File: rtl/uart_cmd_seq.sv
// uart_cmd_seq: serialises register-file/ALU commands into back-to-back UART frames
module uart_cmd_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int RF_ADDR = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CMD_VLD,
  output logic                  CMD_RDY,
  input  logic [1:0]            CMD_TYPE,
  input  logic [RF_ADDR-1:0]    CMD_ADDR,
  input  logic [DATA_WIDTH-1:0] CMD_DATA_A,
  input  logic [DATA_WIDTH-1:0] CMD_DATA_B,
  input  logic [3:0]            CMD_FUN,
  input  logic [5:0]            PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  DONE
);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;
  localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);
  logic [2:0] state, state_n;
  logic [5:0] pcnt, pcnt_n, p_last, ps_q;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [1:0] fcnt, fcnt_n, f_last, typ_q;
  logic [RF_ADDR-1:0] addr_q;
  logic [DATA_WIDTH-1:0] a_q, b_q, addr_x, fun_x, fr;
  logic [3:0] fun_q;
  logic pe_q, pt_q, tx_n, accept;
  assign accept = CMD_VLD && state == IDLE;
  assign CMD_RDY = state == IDLE;
  assign BUSY = state != IDLE;
  assign p_last = ps_q == 6'd0 ? 6'd0 : ps_q - 6'd1;
  assign f_last = typ_q == 2'd2 ? 2'd3 : typ_q == 2'd0 ? 2'd2 : 2'd1;
  assign addr_x = DATA_WIDTH'(addr_q);
  assign fun_x = DATA_WIDTH'(fun_q);
  // payload of the frame being entered, so TX_OUT can be registered without lag
  always_comb begin
    fr = '0;
    case (typ_q)
      2'd0: fr = fcnt_n == 2'd0 ? DATA_WIDTH'(8'hAA) : fcnt_n == 2'd1 ? addr_x : a_q;
      2'd1: fr = fcnt_n == 2'd0 ? DATA_WIDTH'(8'hBB) : addr_x;
      2'd2: fr = fcnt_n == 2'd0 ? DATA_WIDTH'(8'hCC) : fcnt_n == 2'd1 ? a_q : fcnt_n == 2'd2 ? b_q : fun_x;
      default: fr = fcnt_n == 2'd0 ? DATA_WIDTH'(8'hDD) : fun_x;
    endcase
  end
  always_comb begin
    state_n = state;
    pcnt_n = pcnt;
    bcnt_n = bcnt;
    fcnt_n = fcnt;
    if (state == IDLE) begin
      if (CMD_VLD) begin
        state_n = START;
        pcnt_n = '0;
        bcnt_n = '0;
        fcnt_n = '0;
      end
    end else if (pcnt != p_last) begin
      pcnt_n = pcnt + 6'd1;
    end else begin
      pcnt_n = '0;
      case (state)
        START: begin
          state_n = DATA;
          bcnt_n = '0;
        end
        DATA:
          if (bcnt == B_LAST) state_n = pe_q ? PARITY : STOP;
          else bcnt_n = bcnt + 1'b1;
        PARITY: state_n = STOP;
        default:
          if (fcnt == f_last) state_n = IDLE;
          else begin
            state_n = START;
            fcnt_n = fcnt + 2'd1;
          end
      endcase
    end
  end
  assign tx_n = state_n == START ? 1'b0 : state_n == DATA ? fr[bcnt_n] :
                state_n == PARITY ? (^fr) ^ pt_q : 1'b1;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      pcnt <= '0;
      bcnt <= '0;
      fcnt <= '0;
      TX_OUT <= 1'b1;
      DONE <= 1'b0;
      typ_q <= '0;
      addr_q <= '0;
      a_q <= '0;
      b_q <= '0;
      fun_q <= '0;
      ps_q <= '0;
      pe_q <= 1'b0;
      pt_q <= 1'b0;
    end else begin
      state <= state_n;
      pcnt <= pcnt_n;
      bcnt <= bcnt_n;
      fcnt <= fcnt_n;
      TX_OUT <= tx_n;
      DONE <= state != IDLE && state_n == IDLE;
      if (accept) begin
        typ_q <= CMD_TYPE;
        addr_q <= CMD_ADDR;
        a_q <= CMD_DATA_A;
        b_q <= CMD_DATA_B;
        fun_q <= CMD_FUN;
        ps_q <= PRESCALE;
        pe_q <= PAR_EN;
        pt_q <= PAR_TYP;
      end
    end
  end
endmodule
